// File: rtl/bp_me_mmio_router_pkg.sv
// rtl/bp_me_mmio_router_pkg.sv - shared kind encoding, sizing helper and tracker entry macro
package bp_me_router_pkg;

    typedef enum logic {
        e_router_kind_cmd      = 1'b0,
        e_router_kind_data_cmd = 1'b1
    } bp_me_router_kind_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

`ifndef BP_ME_ROUTER_ENTRY_S_VH
`define BP_ME_ROUTER_ENTRY_S_VH
`define DECLARE_BP_ME_ROUTER_ENTRY_S(lg_tgt_mp) \
    typedef struct packed { \
        logic [lg_tgt_mp-1:0] tgt; \
        bp_me_router_kind_e   kind; \
    } bp_me_router_entry_s
`endif

// File: rtl/bp_me_mmio_router_if.sv
// rtl/bp_me_mmio_router_if.sv - upstream client link plus per-target command/response bundle
interface bp_me_mmio_router_if #(
    parameter int num_tgt_p         = 2,
    parameter int paddr_width_p     = 39,
    parameter int cmd_width_p       = 16,
    parameter int data_cmd_width_p  = 32,
    parameter int resp_width_p      = 16,
    parameter int data_resp_width_p = 32
) ();

    logic [num_tgt_p-1:0][paddr_width_p-1:0]     tgt_base_addr_i;

    logic [cmd_width_p-1:0]                      mem_cmd_i;
    logic [paddr_width_p-1:0]                    mem_cmd_addr_i;
    logic                                        mem_cmd_v_i;
    logic                                        mem_cmd_yumi_o;
    logic [data_cmd_width_p-1:0]                 mem_data_cmd_i;
    logic [paddr_width_p-1:0]                    mem_data_cmd_addr_i;
    logic                                        mem_data_cmd_v_i;
    logic                                        mem_data_cmd_yumi_o;

    logic [resp_width_p-1:0]                     mem_resp_o;
    logic                                        mem_resp_v_o;
    logic                                        mem_resp_ready_i;
    logic [data_resp_width_p-1:0]                mem_data_resp_o;
    logic                                        mem_data_resp_v_o;
    logic                                        mem_data_resp_ready_i;

    logic [num_tgt_p-1:0][cmd_width_p-1:0]       tgt_cmd_o;
    logic [num_tgt_p-1:0]                        tgt_cmd_v_o;
    logic [num_tgt_p-1:0]                        tgt_cmd_yumi_i;
    logic [num_tgt_p-1:0][data_cmd_width_p-1:0]  tgt_data_cmd_o;
    logic [num_tgt_p-1:0]                        tgt_data_cmd_v_o;
    logic [num_tgt_p-1:0]                        tgt_data_cmd_yumi_i;

    logic [num_tgt_p-1:0][resp_width_p-1:0]      tgt_resp_i;
    logic [num_tgt_p-1:0]                        tgt_resp_v_i;
    logic [num_tgt_p-1:0]                        tgt_resp_ready_o;
    logic [num_tgt_p-1:0][data_resp_width_p-1:0] tgt_data_resp_i;
    logic [num_tgt_p-1:0]                        tgt_data_resp_v_i;
    logic [num_tgt_p-1:0]                        tgt_data_resp_ready_o;

    modport slave (
        input  tgt_base_addr_i,
        input  mem_cmd_i, mem_cmd_addr_i, mem_cmd_v_i,
        input  mem_data_cmd_i, mem_data_cmd_addr_i, mem_data_cmd_v_i,
        input  mem_resp_ready_i, mem_data_resp_ready_i,
        input  tgt_cmd_yumi_i, tgt_data_cmd_yumi_i,
        input  tgt_resp_i, tgt_resp_v_i, tgt_data_resp_i, tgt_data_resp_v_i,
        output mem_cmd_yumi_o, mem_data_cmd_yumi_o,
        output mem_resp_o, mem_resp_v_o, mem_data_resp_o, mem_data_resp_v_o,
        output tgt_cmd_o, tgt_cmd_v_o, tgt_data_cmd_o, tgt_data_cmd_v_o,
        output tgt_resp_ready_o, tgt_data_resp_ready_o
    );

    modport master (
        output tgt_base_addr_i,
        output mem_cmd_i, mem_cmd_addr_i, mem_cmd_v_i,
        output mem_data_cmd_i, mem_data_cmd_addr_i, mem_data_cmd_v_i,
        output mem_resp_ready_i, mem_data_resp_ready_i,
        output tgt_cmd_yumi_i, tgt_data_cmd_yumi_i,
        output tgt_resp_i, tgt_resp_v_i, tgt_data_resp_i, tgt_data_resp_v_i,
        input  mem_cmd_yumi_o, mem_data_cmd_yumi_o,
        input  mem_resp_o, mem_resp_v_o, mem_data_resp_o, mem_data_resp_v_o,
        input  tgt_cmd_o, tgt_cmd_v_o, tgt_data_cmd_o, tgt_data_cmd_v_o,
        input  tgt_resp_ready_o, tgt_data_resp_ready_o
    );

endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small register-based fifo with valid/ready in and valid/yumi out
module bsg_fifo_1r1w_small
    import bp_me_router_pkg::*;
#(
    parameter int width_p   = 1,
    parameter int els_p     = 1,
    localparam int ptr_w_lp = safe_clog2(els_p),
    localparam int cnt_w_lp = safe_clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
    logic [ptr_w_lp-1:0]           rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]           cnt_q, cnt_d;
    logic                          push, pop;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        ready_o = (cnt_q != cnt_w_lp'(els_p));
        v_o     = (cnt_q != '0);
        data_o  = mem_q[rptr_q];
        push    = v_i & ready_o;
        pop     = yumi_i & v_o;
        mem_d   = mem_q;
        if (push) mem_d[wptr_q] = data_i;
        wptr_d  = push ? wrap_inc(wptr_q) : wptr_q;
        rptr_d  = pop ? wrap_inc(rptr_q) : rptr_q;
        cnt_d   = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_me_mmio_router.sv
// rtl/bp_me_mmio_router.sv - address-decoding cmd/data_cmd router to N targets with in-order response steering
module bp_me_mmio_router
    import bp_me_router_pkg::*;
#(
    parameter int num_tgt_p         = 2,
    parameter int max_outstanding_p = 4,
    parameter int paddr_width_p     = 39,
    parameter int cmd_width_p       = 16,
    parameter int data_cmd_width_p  = 32,
    parameter int resp_width_p      = 16,
    parameter int data_resp_width_p = 32,
    localparam int lg_tgt_lp        = safe_clog2(num_tgt_p),
    localparam int lg_out_lp        = safe_clog2(max_outstanding_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_me_mmio_router_if.slave   bus,
    output logic [lg_out_lp-1:0] outstanding_o,
    output logic                 unexpected_resp_o
);

    `DECLARE_BP_ME_ROUTER_ENTRY_S(lg_tgt_lp);

    bp_me_router_kind_e          rr_q, rr_d, lock_sel_q, lock_sel_d, sel;
    logic                        lock_q, lock_d;
    logic [lg_out_lp-1:0]        cnt_q, cnt_d;
    logic                        sel_v, issue_v, accept, pop, fifo_ready, head_v, head_ok;
    logic [lg_tgt_lp-1:0]        dec_tgt;
    bp_me_router_entry_s         push_entry, head_entry;
    logic [num_tgt_p-1:0]        match_resp, match_data_resp;
    logic [cmd_width_p-1:0]      cmd_pl;
    logic [data_cmd_width_p-1:0] data_cmd_pl;
    logic [resp_width_p-1:0]     resp_pl;
    logic [data_resp_width_p-1:0] data_resp_pl;

    // Bases ascend, so the last base not above the address wins.
    function automatic logic [lg_tgt_lp-1:0] decode(
        input logic [paddr_width_p-1:0]                 addr,
        input logic [num_tgt_p-1:0][paddr_width_p-1:0]  base
    );
        logic [lg_tgt_lp-1:0] r;
        r = '0;
        for (int t = 0; t < num_tgt_p; t++) begin
            if (addr >= base[t]) r = lg_tgt_lp'(t);
        end
        return r;
    endfunction

    always_comb begin
        if (lock_q)                                        sel = lock_sel_q;
        else if (bus.mem_cmd_v_i && bus.mem_data_cmd_v_i)  sel = rr_q;
        else if (bus.mem_data_cmd_v_i)                     sel = e_router_kind_data_cmd;
        else                                               sel = e_router_kind_cmd;

        sel_v   = (sel == e_router_kind_data_cmd) ? bus.mem_data_cmd_v_i : bus.mem_cmd_v_i;
        issue_v = sel_v & fifo_ready & ~reset_i;
        dec_tgt = decode((sel == e_router_kind_data_cmd) ? bus.mem_data_cmd_addr_i
                                                         : bus.mem_cmd_addr_i,
                         bus.tgt_base_addr_i);

        cmd_pl      = bus.mem_cmd_i;
        data_cmd_pl = bus.mem_data_cmd_i;
        for (int t = 0; t < num_tgt_p; t++) begin
            bus.tgt_cmd_o[t]        = cmd_pl;
            bus.tgt_data_cmd_o[t]   = data_cmd_pl;
            bus.tgt_cmd_v_o[t]      = issue_v && (sel == e_router_kind_cmd)
                                      && (dec_tgt == lg_tgt_lp'(t));
            bus.tgt_data_cmd_v_o[t] = issue_v && (sel == e_router_kind_data_cmd)
                                      && (dec_tgt == lg_tgt_lp'(t));
        end

        accept = issue_v && ((sel == e_router_kind_data_cmd) ? bus.tgt_data_cmd_yumi_i[dec_tgt]
                                                              : bus.tgt_cmd_yumi_i[dec_tgt]);
        bus.mem_cmd_yumi_o      = accept && (sel == e_router_kind_cmd);
        bus.mem_data_cmd_yumi_o = accept && (sel == e_router_kind_data_cmd);
        push_entry.tgt  = dec_tgt;
        push_entry.kind = sel;

        // Lock survives a full tracker so the presented channel resumes first.
        if (accept)              lock_d = 1'b0;
        else if (issue_v)        lock_d = 1'b1;
        else if (lock_q && !sel_v) lock_d = 1'b0;
        else                     lock_d = lock_q;
        lock_sel_d = issue_v ? sel : lock_sel_q;
        if (accept) rr_d = (sel == e_router_kind_cmd) ? e_router_kind_data_cmd : e_router_kind_cmd;
        else        rr_d = rr_q;
    end

    always_comb begin
        head_ok = head_v & ~reset_i;
        for (int t = 0; t < num_tgt_p; t++) begin
            match_resp[t]      = head_ok && (head_entry.kind == e_router_kind_data_cmd)
                                 && (head_entry.tgt == lg_tgt_lp'(t));
            match_data_resp[t] = head_ok && (head_entry.kind == e_router_kind_cmd)
                                 && (head_entry.tgt == lg_tgt_lp'(t));
            bus.tgt_resp_ready_o[t]      = match_resp[t] & bus.mem_resp_ready_i;
            bus.tgt_data_resp_ready_o[t] = match_data_resp[t] & bus.mem_data_resp_ready_i;
        end

        resp_pl               = bus.tgt_resp_i[head_entry.tgt];
        data_resp_pl          = bus.tgt_data_resp_i[head_entry.tgt];
        bus.mem_resp_o        = resp_pl;
        bus.mem_data_resp_o   = data_resp_pl;
        bus.mem_resp_v_o      = |(match_resp & bus.tgt_resp_v_i);
        bus.mem_data_resp_v_o = |(match_data_resp & bus.tgt_data_resp_v_i);
        pop = (bus.mem_resp_v_o & bus.mem_resp_ready_i)
            | (bus.mem_data_resp_v_o & bus.mem_data_resp_ready_i);

        unexpected_resp_o = ~reset_i & (|(bus.tgt_resp_v_i & ~match_resp)
                                      | |(bus.tgt_data_resp_v_i & ~match_data_resp));

        cnt_d         = cnt_q + lg_out_lp'(accept) - lg_out_lp'(pop);
        outstanding_o = cnt_q;
    end

    bsg_fifo_1r1w_small #(
        .width_p (lg_tgt_lp + 1),
        .els_p   (max_outstanding_p)
    ) tracker (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (accept),
        .ready_o (fifo_ready),
        .data_i  (push_entry),
        .v_o     (head_v),
        .data_o  (head_entry),
        .yumi_i  (pop)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q       <= e_router_kind_cmd;
            lock_q     <= 1'b0;
            lock_sel_q <= e_router_kind_cmd;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_me_mmio_router.sv
// tb/tb_bp_me_mmio_router.sv - directed self-checking bench for bp_me_mmio_router
module tb_bp_me_mmio_router;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] outstanding;
    logic       unexpected;
    int         total = 0;
    int         bad = 0;

    bp_me_mmio_router_if bus ();

    bp_me_mmio_router dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .bus               (bus),
        .outstanding_o     (outstanding),
        .unexpected_resp_o (unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.mem_cmd_v_i         = 1'b0;
        bus.mem_data_cmd_v_i    = 1'b0;
        bus.tgt_cmd_yumi_i      = '0;
        bus.tgt_data_cmd_yumi_i = '0;
        bus.tgt_resp_v_i        = '0;
        bus.tgt_data_resp_v_i   = '0;
    endtask

    initial begin
        bus.tgt_base_addr_i[0]    = '0;
        bus.tgt_base_addr_i[1]    = 39'h00_8000_0000;
        bus.mem_cmd_i             = '0;
        bus.mem_cmd_addr_i        = '0;
        bus.mem_data_cmd_i        = '0;
        bus.mem_data_cmd_addr_i   = '0;
        bus.mem_resp_ready_i      = 1'b1;
        bus.mem_data_resp_ready_i = 1'b1;
        bus.tgt_resp_i[0]         = 16'h0a0a;
        bus.tgt_resp_i[1]         = 16'h0055;
        bus.tgt_data_resp_i[0]    = 32'hcafe_0000;
        bus.tgt_data_resp_i[1]    = 32'hbeef_0001;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // reset state
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_cmd_v", bus.tgt_cmd_v_o, 0);
        chk("rst_data_cmd_v", bus.tgt_data_cmd_v_o, 0);
        chk("rst_resp_ready", bus.tgt_resp_ready_o, 0);
        chk("rst_data_resp_ready", bus.tgt_data_resp_ready_o, 0);
        chk("rst_mem_resp_v", bus.mem_resp_v_o, 0);
        chk("rst_unexpected", unexpected, 0);
        cyc();

        // cmd 0x4000 -> target 0
        bus.mem_cmd_v_i = 1'b1; bus.mem_cmd_addr_i = 39'h4000; bus.mem_cmd_i = 16'h1234;
        bus.tgt_cmd_yumi_i = 2'b01;
        #1;
        chk("dec_cmd_v", bus.tgt_cmd_v_o, 2'b01);
        chk("dec_cmd_dv", bus.tgt_data_cmd_v_o, 2'b00);
        chk("dec_cmd_payload", bus.tgt_cmd_o[0], 16'h1234);
        chk("dec_cmd_yumi", bus.mem_cmd_yumi_o, 1);
        cyc();
        idle_inputs();

        // data_cmd 0x8000_0040 -> target 1
        bus.mem_data_cmd_v_i = 1'b1; bus.mem_data_cmd_addr_i = 39'h00_8000_0040;
        bus.mem_data_cmd_i = 32'hdead_beef; bus.tgt_data_cmd_yumi_i = 2'b10;
        #1;
        chk("dec_dcmd_v", bus.tgt_data_cmd_v_o, 2'b10);
        chk("dec_dcmd_payload", bus.tgt_data_cmd_o[1], 32'hdead_beef);
        chk("dec_dcmd_yumi", bus.mem_data_cmd_yumi_o, 1);
        chk("out_one", outstanding, 1);
        cyc();
        idle_inputs();
        #1;
        chk("out_two", outstanding, 2);

        // head is target 0 read; target 1 ack must wait
        bus.tgt_resp_v_i = 2'b10;
        #1;
        chk("order_t1_ready_a", bus.tgt_resp_ready_o, 0);
        chk("order_unexp_a", unexpected, 1);
        chk("order_mem_resp_v_a", bus.mem_resp_v_o, 0);
        cyc();
        #1;
        chk("order_t1_ready_b", bus.tgt_resp_ready_o, 0);
        chk("order_unexp_b", unexpected, 1);
        cyc();
        bus.tgt_data_resp_v_i = 2'b01;
        #1;
        chk("order_t0_ready", bus.tgt_data_resp_ready_o, 2'b01);
        chk("order_mem_dresp_v", bus.mem_data_resp_v_o, 1);
        chk("order_mem_dresp", bus.mem_data_resp_o, 32'hcafe_0000);
        chk("order_t1_still_blocked", bus.tgt_resp_ready_o, 0);
        cyc();
        bus.tgt_data_resp_v_i = 2'b00;
        #1;
        chk("order_t1_accept_ready", bus.tgt_resp_ready_o, 2'b10);
        chk("order_t1_mem_v", bus.mem_resp_v_o, 1);
        chk("order_t1_mem_resp", bus.mem_resp_o, 16'h0055);
        chk("order_t1_unexp", unexpected, 0);
        chk("order_out_before", outstanding, 1);
        cyc();
        idle_inputs();
        #1;
        chk("order_out_empty", outstanding, 0);

        // response with tracker empty
        bus.tgt_data_resp_v_i = 2'b01;
        #1;
        chk("empty_ready", bus.tgt_data_resp_ready_o, 0);
        chk("empty_unexp", unexpected, 1);
        chk("empty_mem_v", bus.mem_data_resp_v_o, 0);
        cyc();
        bus.tgt_data_resp_v_i = 2'b00;
        #1;
        chk("empty_unexp_end", unexpected, 0);
        chk("empty_out", outstanding, 0);

        // both channels valid, targets always yumi: cmd then data_cmd
        bus.mem_cmd_v_i = 1'b1; bus.mem_cmd_addr_i = 39'h100;
        bus.mem_data_cmd_v_i = 1'b1; bus.mem_data_cmd_addr_i = 39'h00_8000_0100;
        bus.tgt_cmd_yumi_i = 2'b11; bus.tgt_data_cmd_yumi_i = 2'b11;
        #1;
        chk("rr0_cmd_yumi", bus.mem_cmd_yumi_o, 1);
        chk("rr0_dcmd_yumi", bus.mem_data_cmd_yumi_o, 0);
        chk("rr0_cmd_v", bus.tgt_cmd_v_o, 2'b01);
        cyc();
        #1;
        chk("rr1_cmd_yumi", bus.mem_cmd_yumi_o, 0);
        chk("rr1_dcmd_yumi", bus.mem_data_cmd_yumi_o, 1);
        chk("rr1_dcmd_v", bus.tgt_data_cmd_v_o, 2'b10);
        cyc();

        // data_cmd alone then stalls; cmd arrives with priority but lock holds
        bus.mem_cmd_v_i = 1'b0;
        bus.tgt_cmd_yumi_i = 2'b00; bus.tgt_data_cmd_yumi_i = 2'b00;
        #1;
        chk("lock_s0_dv", bus.tgt_data_cmd_v_o, 2'b10);
        chk("lock_s0_cv", bus.tgt_cmd_v_o, 2'b00);
        cyc();
        bus.mem_cmd_v_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_hold_dv", bus.tgt_data_cmd_v_o, 2'b10);
            chk("lock_hold_cv", bus.tgt_cmd_v_o, 2'b00);
            chk("lock_hold_yumi", bus.mem_data_cmd_yumi_o, 0);
            cyc();
        end
        bus.tgt_data_cmd_yumi_i = 2'b10;
        #1;
        chk("lock_rel_dyumi", bus.mem_data_cmd_yumi_o, 1);
        chk("lock_rel_cyumi", bus.mem_cmd_yumi_o, 0);
        cyc();
        bus.mem_data_cmd_v_i = 1'b0;
        bus.tgt_cmd_yumi_i = 2'b01;
        #1;
        chk("fill4_cmd_yumi", bus.mem_cmd_yumi_o, 1);
        chk("fill4_out", outstanding, 3);
        cyc();
        idle_inputs();

        // tracker full: 5th request held off
        bus.mem_data_cmd_v_i = 1'b1; bus.mem_data_cmd_addr_i = 39'h200;
        bus.tgt_data_cmd_yumi_i = 2'b11;
        #1;
        chk("full_out", outstanding, 4);
        chk("full_dv", bus.tgt_data_cmd_v_o, 2'b00);
        chk("full_cv", bus.tgt_cmd_v_o, 2'b00);
        chk("full_yumi", bus.mem_data_cmd_yumi_o, 0);
        cyc();
        bus.tgt_data_resp_v_i = 2'b01;
        #1;
        chk("full_pop_ready", bus.tgt_data_resp_ready_o, 2'b01);
        chk("full_pop_dv", bus.tgt_data_cmd_v_o, 2'b00);
        cyc();
        bus.tgt_data_resp_v_i = 2'b00;
        #1;
        chk("full_after_out", outstanding, 3);
        chk("full_after_dv", bus.tgt_data_cmd_v_o, 2'b01);
        chk("full_after_yumi", bus.mem_data_cmd_yumi_o, 1);
        cyc();
        idle_inputs();

        // pop one (head is target 1 write) to leave 3 outstanding
        bus.tgt_resp_v_i = 2'b10;
        #1;
        chk("pre_rst_ready", bus.tgt_resp_ready_o, 2'b10);
        chk("pre_rst_out", outstanding, 4);
        cyc();
        idle_inputs();
        #1;
        chk("pre_rst_out3", outstanding, 3);

        // reset mid-transaction
        reset = 1'b1;
        cyc();
        #1;
        chk("midrst_out", outstanding, 0);
        chk("midrst_cv", bus.tgt_cmd_v_o, 0);
        chk("midrst_dv", bus.tgt_data_cmd_v_o, 0);
        chk("midrst_rready", bus.tgt_resp_ready_o, 0);
        chk("midrst_drready", bus.tgt_data_resp_ready_o, 0);
        chk("midrst_memv", bus.mem_resp_v_o | bus.mem_data_resp_v_o, 0);
        chk("midrst_unexp", unexpected, 0);
        reset = 1'b0;
        cyc();

        // fresh cmd after reset; then wrong-channel response from head target
        bus.mem_cmd_v_i = 1'b1; bus.mem_cmd_addr_i = 39'h10; bus.tgt_cmd_yumi_i = 2'b01;
        #1;
        chk("post_rst_yumi", bus.mem_cmd_yumi_o, 1);
        cyc();
        idle_inputs();
        bus.tgt_resp_v_i = 2'b01;
        #1;
        chk("post_rst_out", outstanding, 1);
        chk("wrong_ch_ready", bus.tgt_resp_ready_o, 0);
        chk("wrong_ch_unexp", unexpected, 1);
        cyc();
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
